// File: rtl/pacman_pkg.sv
// Shared definitions for the game-status stage: collision codes, game states,
// seven-segment glyphs and the saturating BCD score adder.
package pacman_pkg;

  localparam logic [3:0] COLL_NONE  = 4'd0;
  localparam logic [3:0] COLL_WALL  = 4'd1;
  localparam logic [3:0] COLL_PILL  = 4'd2;
  localparam logic [3:0] COLL_POWER = 4'd3;
  localparam logic [3:0] COLL_GHOST = 4'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DYING = 3'd2,
    OVER  = 3'd3,
    WON   = 3'd4
  } game_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  localparam logic [15:0] PTS_PILL  = 16'h0010;
  localparam logic [15:0] PTS_POWER = 16'h0050;
  localparam logic [15:0] PTS_GHOST = 16'h0200;

  // Digit-wise decimal add; a carry out of the thousands digit clamps to 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    if (c) begin
      r = 16'h9999;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (gfedcba); non-decimal codes blank.
module seg7_decode
  import pacman_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_lives_ctrl.sv
// Game-status stage: turns collision events into score, lives, frightened window
// and game state, and drives the six seven-segment displays.
module score_lives_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned TOTAL_PILLS   = 244,
  parameter logic [31:0] FRIGHT_CYCLES = 32'd400_000_000,
  parameter logic [31:0] DEATH_CYCLES  = 32'd100_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       coll_valid,
  input  logic [3:0] collision_type,
  output logic       frightened,
  output logic       freeze,
  output logic       life_lost,
  output logic       game_over,
  output logic       win,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [3:0] LIVES_RST   = 4'(LIVES_INIT);
  localparam logic [7:0] PILL_TARGET = 8'(TOTAL_PILLS);

  game_state_t state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  lives_q, lives_d;
  logic [7:0]  pills_q, pills_d;
  logic [31:0] fright_q, fright_d;
  logic [31:0] death_q, death_d;
  logic        life_lost_q, life_lost_d;
  logic [6:0]  hex_q [6];
  logic [6:0]  hex_d [6];

  logic [15:0]      disp_score;
  logic [3:0]       disp_lives;
  game_state_t      disp_state;
  logic [4:0][6:0]  seg_digit;

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    pills_d     = pills_q;
    fright_d    = fright_q;
    death_d     = death_q;
    life_lost_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (fright_q != 32'd0) begin
          fright_d = fright_q - 32'd1;
        end
        if (coll_valid) begin
          case (collision_type)
            COLL_PILL: begin
              score_d = bcd_add_sat(score_q, PTS_PILL);
              pills_d = pills_q + 8'd1;
              if (pills_d == PILL_TARGET) begin
                state_d = WON;
              end
            end
            COLL_POWER: begin
              score_d  = bcd_add_sat(score_q, PTS_POWER);
              pills_d  = pills_q + 8'd1;
              fright_d = FRIGHT_CYCLES;
              if (pills_d == PILL_TARGET) begin
                state_d = WON;
              end
            end
            COLL_GHOST: begin
              // Pre-decrement counter decides, so a ghost on the last frightened cycle still scores.
              if (fright_q != 32'd0) begin
                score_d = bcd_add_sat(score_q, PTS_GHOST);
              end else begin
                fright_d = 32'd0;
                lives_d  = lives_q - 4'd1;
                if (lives_q == 4'd1) begin
                  state_d = OVER;
                end else begin
                  state_d     = DYING;
                  death_d     = DEATH_CYCLES - 32'd1;
                  life_lost_d = 1'b1;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end

      DYING: begin
        if (death_q == 32'd0) begin
          state_d = PLAY;
        end else begin
          death_d = death_q - 32'd1;
        end
      end

      default: begin
      end
    endcase
  end

  // Display sources fall back to reset values so the HEX registers load them on the reset edge.
  always_comb begin
    disp_score = score_q;
    disp_lives = lives_q;
    disp_state = state_q;
    if (!reset) begin
      disp_score = 16'h0000;
      disp_lives = LIVES_RST;
      disp_state = IDLE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_score_seg
      seg7_decode u_seg (
        .bcd (disp_score[4*gi +: 4]),
        .seg (seg_digit[gi])
      );
    end
  endgenerate

  seg7_decode u_seg_lives (
    .bcd (disp_lives),
    .seg (seg_digit[4])
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hex_d[i] = seg_digit[i];
    end
    case (disp_state)
      OVER:    hex_d[4] = SEG_E;
      WON:     hex_d[4] = SEG_P;
      default: hex_d[4] = SEG_BLANK;
    endcase
    hex_d[5] = seg_digit[4];
  end

  always_ff @(posedge CLOCK_50) begin
    hex_q <= hex_d;
    if (!reset) begin
      state_q     <= IDLE;
      score_q     <= 16'h0000;
      lives_q     <= LIVES_RST;
      pills_q     <= 8'd0;
      fright_q    <= 32'd0;
      death_q     <= 32'd0;
      life_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      pills_q     <= pills_d;
      fright_q    <= fright_d;
      death_q     <= death_d;
      life_lost_q <= life_lost_d;
    end
  end

  assign frightened = (fright_q != 32'd0);
  assign freeze     = (state_q != PLAY);
  assign life_lost  = life_lost_q;
  assign game_over  = (state_q == OVER);
  assign win        = (state_q == WON);

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_score_lives_ctrl.sv
// Directed bench for score_lives_ctrl: instance A plays the main game scenarios,
// instance B (four-pill board) covers the win path.
module tb_score_lives_ctrl;

  localparam logic [31:0] FR  = 32'd100;
  localparam logic [31:0] DC  = 32'd20;
  localparam int          FRI = 100;
  localparam int          DCI = 20;

  localparam logic [3:0] C_PILL  = 4'd2;
  localparam logic [3:0] C_POWER = 4'd3;
  localparam logic [3:0] C_GHOST = 4'd4;

  localparam int ST_IDLE  = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_DYING = 2;
  localparam int ST_OVER  = 3;
  localparam int ST_WON   = 4;

  typedef struct {
    int score;
    int lives;
    int st;
    int fright_end;
    bit ll;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rst_b, start_v, coll_v, sel;
  logic [3:0] code_v;
  logic       fr_a, fz_a, ll_a, go_a, win_a;
  logic       fr_b, fz_b, ll_b, go_b, win_b;
  logic [6:0] hex_a [6];
  logic [6:0] hex_b [6];
  logic [6:0] hex [6];
  logic       fr, fz, ll, go, wn;

  score_lives_ctrl #(
    .LIVES_INIT(3), .TOTAL_PILLS(200), .FRIGHT_CYCLES(FR), .DEATH_CYCLES(DC)
  ) u_dut_a (
    .CLOCK_50(clk), .reset(rst_a), .start(start_v & ~sel),
    .coll_valid(coll_v & ~sel), .collision_type(code_v),
    .frightened(fr_a), .freeze(fz_a), .life_lost(ll_a), .game_over(go_a), .win(win_a),
    .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]),
    .HEX3(hex_a[3]), .HEX4(hex_a[4]), .HEX5(hex_a[5])
  );

  score_lives_ctrl #(
    .LIVES_INIT(3), .TOTAL_PILLS(4), .FRIGHT_CYCLES(FR), .DEATH_CYCLES(DC)
  ) u_dut_b (
    .CLOCK_50(clk), .reset(rst_b), .start(start_v & sel),
    .coll_valid(coll_v & sel), .collision_type(code_v),
    .frightened(fr_b), .freeze(fz_b), .life_lost(ll_b), .game_over(go_b), .win(win_b),
    .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]),
    .HEX3(hex_b[3]), .HEX4(hex_b[4]), .HEX5(hex_b[5])
  );

  always_comb begin
    fr = sel ? fr_b  : fr_a;
    fz = sel ? fz_b  : fz_a;
    ll = sel ? ll_b  : ll_a;
    go = sel ? go_b  : go_a;
    wn = sel ? win_b : win_a;
    for (int i = 0; i < 6; i++) begin
      hex[i] = sel ? hex_b[i] : hex_a[i];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int score_m, lives_m, pills_m, st_m, fright_end, dying_end, total_m;
  exp_t sb[$];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] score_segs(input int s);
    return {seg((s / 1000) % 10), seg((s / 100) % 10), seg((s / 10) % 10), seg(s % 10)};
  endfunction

  function automatic logic [6:0] hex4_exp(input int st);
    if (st == ST_OVER) return 7'b0000110;
    if (st == ST_WON)  return 7'b0001100;
    return 7'h7F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_state(input int c);
    if (st_m == ST_DYING && c > dying_end) st_m = ST_PLAY;
  endtask

  task automatic add_score(input int pts);
    score_m = (score_m + pts > 9999) ? 9999 : score_m + pts;
  endtask

  task automatic pill_hit();
    pills_m++;
    if (pills_m == total_m) st_m = ST_WON;
  endtask

  task automatic model_reset();
    score_m = 0; lives_m = 3; pills_m = 0; st_m = ST_IDLE;
    fright_end = -1; dying_end = -1;
    total_m = sel ? 4 : 200;
  endtask

  // Compare every output against the model for a state that has been stable a cycle.
  task automatic check_now(input string tag, input bit exp_ll);
    upd_state(cyc);
    chk({tag, ".frightened"}, 32'(fr), 32'(cyc <= fright_end));
    chk({tag, ".freeze"},     32'(fz), 32'(st_m != ST_PLAY));
    chk({tag, ".life_lost"},  32'(ll), 32'(exp_ll));
    chk({tag, ".game_over"},  32'(go), 32'(st_m == ST_OVER));
    chk({tag, ".win"},        32'(wn), 32'(st_m == ST_WON));
    chk({tag, ".hex3_0"}, {4'h0, hex[3], hex[2], hex[1], hex[0]}, {4'h0, score_segs(score_m)});
    chk({tag, ".hex4"}, 32'(hex[4]), 32'(hex4_exp(st_m)));
    chk({tag, ".hex5"}, 32'(hex[5]), 32'(seg(lives_m)));
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    coll_v = 1'b0;
    model_reset();
    @(negedge clk);
    check_now(tag, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  task automatic pulse_start(input string tag);
    int e;
    @(negedge clk);
    start_v = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start_v = 1'b0;
    upd_state(e - 1);
    if (st_m == ST_IDLE) st_m = ST_PLAY;
    @(negedge clk);
    check_now(tag, 1'b0);
  endtask

  // One collision event: model result pushed when driven, popped at N+1 and N+2.
  task automatic ev(input logic [3:0] code, input string tag, output int edge_n);
    exp_t e;
    logic [27:0] old_segs;
    @(negedge clk);
    edge_n = cyc + 1;
    old_segs = score_segs(score_m);
    upd_state(edge_n - 1);
    coll_v = 1'b1;
    code_v = code;
    e.ll = 1'b0;
    if (st_m == ST_PLAY) begin
      case (code)
        C_PILL: begin
          add_score(10);
          pill_hit();
        end
        C_POWER: begin
          add_score(50);
          fright_end = edge_n + FRI - 1;
          pill_hit();
        end
        C_GHOST: begin
          if (edge_n - 1 <= fright_end) begin
            add_score(200);
          end else begin
            fright_end = -1;
            lives_m--;
            if (lives_m == 0) begin
              st_m = ST_OVER;
            end else begin
              st_m = ST_DYING;
              dying_end = edge_n + DCI - 1;
              e.ll = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
    e.score = score_m;
    e.lives = lives_m;
    e.st = st_m;
    e.fright_end = fright_end;
    sb.push_back(e);

    @(negedge clk);
    coll_v = 1'b0;
    code_v = 4'd0;
    e = sb.pop_front();
    chk({tag, ".n1.frightened"}, 32'(fr), 32'(cyc <= e.fright_end));
    chk({tag, ".n1.freeze"},     32'(fz), 32'(e.st != ST_PLAY));
    chk({tag, ".n1.life_lost"},  32'(ll), 32'(e.ll));
    chk({tag, ".n1.game_over"},  32'(go), 32'(e.st == ST_OVER));
    chk({tag, ".n1.win"},        32'(wn), 32'(e.st == ST_WON));
    chk({tag, ".n1.hex_old"}, {4'h0, hex[3], hex[2], hex[1], hex[0]}, {4'h0, old_segs});

    @(negedge clk);
    chk({tag, ".n2.life_lost"}, 32'(ll), 32'(0));
    chk({tag, ".n2.hex3_0"}, {4'h0, hex[3], hex[2], hex[1], hex[0]}, {4'h0, score_segs(e.score)});
    chk({tag, ".n2.hex4"}, 32'(hex[4]), 32'(hex4_exp(e.st)));
    chk({tag, ".n2.hex5"}, 32'(hex[5]), 32'(seg(e.lives)));
    $display("event %s code=%0d edge=%0d score=%0d lives=%0d state=%0d", tag, code, edge_n, e.score, e.lives, e.st);
  endtask

  initial begin
    int p1, p2, p3, g1, g2, g3, t;
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    start_v = 1'b0; coll_v = 1'b0; code_v = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    do_reset("reset_a");
    ev(C_PILL, "idle_pill_ignored", t);
    pulse_start("start");
    for (int i = 0; i < 3; i++) ev(C_PILL, "pill", t);

    ev(C_POWER, "power1", p1);
    wait_cyc(p1 + 8);
    ev(C_GHOST, "ghost_fright", t);
    wait_cyc(p1 + 48);
    ev(C_POWER, "power_rearm", p2);
    wait_cyc(p1 + FRI);
    check_now("rearm_extends", 1'b0);
    wait_cyc(p2 + FRI - 2);
    check_now("fright_last_cycle", 1'b0);
    ev(C_GHOST, "ghost_at_expiry", t);

    ev(C_GHOST, "ghost_kill1", g1);
    ev(C_PILL, "dying_pill_ignored", t);
    start_v = 1'b1;
    wait_cyc(g1 + DCI - 1);
    check_now("dying_end", 1'b0);
    @(negedge clk);
    check_now("dying_to_play", 1'b0);
    start_v = 1'b0;

    ev(C_PILL, "pill_after_dying", t);
    ev(C_POWER, "power_sat", p3);
    for (int i = 0; i < 49; i++) ev(C_GHOST, "ghost_sat", t);

    wait_cyc(p3 + FRI + 2);
    ev(C_GHOST, "ghost_kill2", g2);
    wait_cyc(g2 + DCI + 1);
    ev(C_GHOST, "ghost_kill3", g3);
    ev(C_POWER, "over_power_ignored", t);
    ev(C_PILL, "over_pill_ignored", t);
    pulse_start("over_start_ignored");

    do_reset("reset_after_over");
    pulse_start("restart");
    ev(C_GHOST, "ghost_kill_mid", g1);
    repeat (5) @(negedge clk);
    do_reset("reset_mid_dying");

    sel = 1'b1;
    do_reset("reset_b");
    pulse_start("start_b");
    for (int i = 0; i < 4; i++) ev(C_PILL, "pill_b", t);
    ev(C_PILL, "won_pill_ignored", t);
    pulse_start("won_start_ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed cycle %0d, required finish before timeout", cyc);
    $fatal(1, "timeout");
  end

endmodule
